// File: rtl/processing_pkg.sv
// Shared definitions for the pulse processing chain: trigger-mode encodings,
// FSM state encodings and default data-path widths.
package processing_pkg;

  localparam int unsigned ADC_W_DEF = 16;
  localparam int unsigned TS_W_DEF  = 64;

  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REPORT  = 2'd2
  } pwc_state_t;

endpackage

// File: rtl/pulse_trigger_detect.sv
// Per-sample trigger decision for the pulse front-end.
// Keeps the previous sample for edge detection and muxes level/edge mode.
// Ports:
//   clk210_p, reset_p   clock and synchronous active-high reset
//   sample_valid        sample is valid this cycle
//   sample              unsigned ADC sample
//   trig_mode           TRIG_LEVEL / TRIG_EDGE
//   trig_threshold      unsigned threshold
//   trig_c              combinational trigger for the current valid sample
module pulse_trigger_detect
  import processing_pkg::*;
#(
  parameter int unsigned ADC_W = ADC_W_DEF
) (
  input  logic             clk210_p,
  input  logic             reset_p,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  input  logic             trig_mode,
  input  logic [ADC_W-1:0] trig_threshold,
  output logic             trig_c
);

  logic [ADC_W-1:0]  prev_q;
  logic              prev_valid_q;
  logic signed [ADC_W:0] delta_c;
  logic signed [ADC_W:0] thr_c;

  // Previous sample tracks every valid sample regardless of FSM state.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (sample_valid) begin
      prev_q       <= sample;
      prev_valid_q <= 1'b1;
    end
  end

  // Difference is taken one bit wider so a falling slope stays negative.
  always_comb begin
    delta_c = $signed({1'b0, sample}) - $signed({1'b0, prev_q});
    thr_c   = $signed({1'b0, trig_threshold});
    trig_c  = 1'b0;
    if (sample_valid) begin
      if (trig_mode == TRIG_EDGE) trig_c = prev_valid_q && (delta_c > thr_c);
      else                        trig_c = (sample > trig_threshold);
    end
  end

endmodule

// File: rtl/pulse_window_capture.sv
// Pulse front-end: drains the ADC FIFO, triggers on level or rising edge,
// captures a WIN_LEN-sample window and reports one record per event.
// Ports:
//   clk210_p, reset_p        clock and synchronous active-high reset
//   fifo_adc_rd_en_p         FIFO read enable (data valid one cycle later)
//   fifo_adc_data_count_p    FIFO occupancy
//   fifo_adc_dout_p          {time stamp, sample}
//   trig_mode_p              0 level, 1 rising edge
//   trig_threshold_p         unsigned trigger threshold
//   result_valid_p/ready_p   result handshake
//   result_ts_p/peak_p/peak_idx_p/sum_p  event record
//   event_count_p            completed events, wrapping
module pulse_window_capture
  import processing_pkg::*;
#(
  parameter int unsigned ADC_W   = ADC_W_DEF,
  parameter int unsigned TS_W    = TS_W_DEF,
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned IDX_W   = $clog2(WIN_LEN),
  parameter int unsigned SUM_W   = ADC_W + $clog2(WIN_LEN) + 1
) (
  input  logic                  clk210_p,
  input  logic                  reset_p,
  output logic                  fifo_adc_rd_en_p,
  input  logic [CNT_W-1:0]      fifo_adc_data_count_p,
  input  logic [TS_W+ADC_W-1:0] fifo_adc_dout_p,
  input  logic                  trig_mode_p,
  input  logic [ADC_W-1:0]      trig_threshold_p,
  output logic                  result_valid_p,
  input  logic                  result_ready_p,
  output logic [TS_W-1:0]       result_ts_p,
  output logic [ADC_W-1:0]      result_peak_p,
  output logic [IDX_W-1:0]      result_peak_idx_p,
  output logic [SUM_W-1:0]      result_sum_p,
  output logic [15:0]           event_count_p
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  pwc_state_t       state_q, state_d;
  logic             rd_en_c;
  logic             sample_valid_q;
  logic             trig_c;
  logic             reads_done_c;
  logic             win_last_c;
  logic [IDX_W-1:0] rd_cnt_q;
  logic [IDX_W-1:0] win_idx_q;
  logic [ADC_W-1:0] sample_c;
  logic [TS_W-1:0]  ts_c;
  logic             valid_q;
  logic [TS_W-1:0]  ts_q;
  logic [ADC_W-1:0] peak_q;
  logic [IDX_W-1:0] peak_idx_q;
  logic [SUM_W-1:0] sum_q;
  logic [15:0]      event_count_q;

  assign sample_c = fifo_adc_dout_p[ADC_W-1:0];
  assign ts_c     = fifo_adc_dout_p[TS_W+ADC_W-1:ADC_W];

  pulse_trigger_detect #(.ADC_W(ADC_W)) u_trig (
    .clk210_p       (clk210_p),
    .reset_p        (reset_p),
    .sample_valid   (sample_valid_q),
    .sample         (sample_c),
    .trig_mode      (trig_mode_p),
    .trig_threshold (trig_threshold_p),
    .trig_c         (trig_c)
  );

  // rd_cnt counts post-trigger reads; reaching LAST_IDX means the window is fully requested.
  assign reads_done_c = (state_q == CAPTURE) && (rd_cnt_q == LAST_IDX);
  assign win_last_c   = (IDX_W'(win_idx_q + IDX_W'(1)) == LAST_IDX);

  // State register.
  always_ff @(posedge clk210_p) begin
    if (reset_p) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and FIFO read enable.
  always_comb begin
    state_d = state_q;
    rd_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        rd_en_c = (fifo_adc_data_count_p != '0);
        if (trig_c) state_d = CAPTURE;
      end
      CAPTURE: begin
        rd_en_c = (fifo_adc_data_count_p != '0) && !reads_done_c;
        if (sample_valid_q && win_last_c) state_d = REPORT;
      end
      REPORT: begin
        if (result_ready_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset_p) rd_en_c = 1'b0;
  end

  // Read pipeline, window accumulators and result registers.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      sample_valid_q <= 1'b0;
      rd_cnt_q       <= '0;
      win_idx_q      <= '0;
      valid_q        <= 1'b0;
      ts_q           <= '0;
      peak_q         <= '0;
      peak_idx_q     <= '0;
      sum_q          <= '0;
      event_count_q  <= '0;
    end else begin
      sample_valid_q <= rd_en_c;
      valid_q        <= (state_d == REPORT);
      case (state_q)
        IDLE: begin
          if (trig_c) begin
            ts_q       <= ts_c;
            peak_q     <= sample_c;
            peak_idx_q <= '0;
            sum_q      <= SUM_W'(sample_c);
            win_idx_q  <= '0;
            // A read issued alongside the trigger sample already fetches index 1.
            rd_cnt_q   <= rd_en_c ? IDX_W'(1) : '0;
          end
        end
        CAPTURE: begin
          if (rd_en_c) rd_cnt_q <= rd_cnt_q + IDX_W'(1);
          if (sample_valid_q) begin
            win_idx_q <= win_idx_q + IDX_W'(1);
            sum_q     <= sum_q + SUM_W'(sample_c);
            if (sample_c > peak_q) begin
              peak_q     <= sample_c;
              peak_idx_q <= win_idx_q + IDX_W'(1);
            end
          end
        end
        REPORT: begin
          if (result_ready_p) begin
            event_count_q <= event_count_q + 16'd1;
            rd_cnt_q      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_adc_rd_en_p  = rd_en_c;
  assign result_valid_p    = valid_q;
  assign result_ts_p       = ts_q;
  assign result_peak_p     = peak_q;
  assign result_peak_idx_p = peak_idx_q;
  assign result_sum_p      = sum_q;
  assign event_count_p     = event_count_q;

endmodule

// File: tb/tb_pulse_window_capture.sv
// Bench for pulse_window_capture: two instances (WIN_LEN 16 and 8) fed by
// behavioural FIFO models; table vectors, corner sequences and random streams.
module tb_pulse_window_capture;

  localparam int unsigned ADC_W = 16;
  localparam int unsigned TS_W  = 64;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned DW    = TS_W + ADC_W;

  logic             clk210_p = 1'b0;
  logic             reset_p  = 1'b1;
  logic             trig_mode = 1'b0;
  logic [ADC_W-1:0] thr = '0;

  logic             rd_en [2];
  logic [CNT_W-1:0] cnt   [2];
  logic [DW-1:0]    dout  [2];
  logic             valid [2];
  logic             ready [2];
  logic [TS_W-1:0]  ts    [2];
  logic [ADC_W-1:0] peak  [2];
  logic [15:0]      evc   [2];
  logic [3:0]       idx0;
  logic [2:0]       idx1;
  logic [20:0]      sum0;
  logic [19:0]      sum1;

  logic [DW-1:0] mem [2][0:2047];
  int  wr_ptr   [2];
  int  rd_ptr   [2];
  int  rd_pulses[2];
  int  overread [2];
  logic force_empty [2];

  int n_cmp  = 0;
  int n_fail = 0;

  always #2 clk210_p = ~clk210_p;

  pulse_window_capture #(.WIN_LEN(16)) dut16 (
    .clk210_p(clk210_p), .reset_p(reset_p),
    .fifo_adc_rd_en_p(rd_en[0]), .fifo_adc_data_count_p(cnt[0]), .fifo_adc_dout_p(dout[0]),
    .trig_mode_p(trig_mode), .trig_threshold_p(thr),
    .result_valid_p(valid[0]), .result_ready_p(ready[0]), .result_ts_p(ts[0]),
    .result_peak_p(peak[0]), .result_peak_idx_p(idx0), .result_sum_p(sum0),
    .event_count_p(evc[0])
  );

  pulse_window_capture #(.WIN_LEN(8)) dut8 (
    .clk210_p(clk210_p), .reset_p(reset_p),
    .fifo_adc_rd_en_p(rd_en[1]), .fifo_adc_data_count_p(cnt[1]), .fifo_adc_dout_p(dout[1]),
    .trig_mode_p(trig_mode), .trig_threshold_p(thr),
    .result_valid_p(valid[1]), .result_ready_p(ready[1]), .result_ts_p(ts[1]),
    .result_peak_p(peak[1]), .result_peak_idx_p(idx1), .result_sum_p(sum1),
    .event_count_p(evc[1])
  );

  // FIFO models: occupancy, optional forced-empty, one-cycle read latency.
  always_comb begin
    for (int k = 0; k < 2; k++)
      cnt[k] = force_empty[k] ? '0 : CNT_W'(wr_ptr[k] - rd_ptr[k]);
  end

  always @(posedge clk210_p) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) begin
        if (wr_ptr[k] - rd_ptr[k] <= 0 || force_empty[k]) overread[k] <= overread[k] + 1;
        dout[k]      <= mem[k][rd_ptr[k] & 2047];
        rd_ptr[k]    <= rd_ptr[k] + 1;
        rd_pulses[k] <= rd_pulses[k] + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk210_p);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input longint t, input int s);
    mem[k][wr_ptr[k] & 2047] = {64'(t), 16'(s)};
    wr_ptr[k] = wr_ptr[k] + 1;
  endtask

  task automatic get_out(input int k, output longint t, output int p, output int ix, output int s);
    t = longint'(ts[k]);
    p = int'(peak[k]);
    ix = (k == 0) ? int'(idx0) : int'(idx1);
    s  = (k == 0) ? int'(sum0) : int'(sum1);
  endtask

  task automatic do_reset();
    reset_p  = 1'b1;
    ready[0] = 1'b0;
    ready[1] = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      wr_ptr[k]      = rd_ptr[k];
      force_empty[k] = 1'b0;
    end
    reset_p = 1'b0;
  endtask

  task automatic wait_valid(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (valid[k]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_valid dut%0d: got no result_valid, expected one within 400 cycles", k);
    end
  endtask

  task automatic wait_reads(input int k, input int base, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rd_pulses[k] - base >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_reads dut%0d: got %0d reads, expected %0d", k, rd_pulses[k] - base, n);
    end
  endtask

  task automatic accept(input int k);
    ready[k] = 1'b1;
    tick();
    ready[k] = 1'b0;
  endtask

  typedef struct {
    bit mode; int thr; int k;
    longint exp_ts; int exp_peak; int exp_idx; int exp_sum; int exp_rd;
  } row_t;

  typedef struct { longint ts; int peak; int idx; int sum; } exp_t;

  int     stream [16] = '{5166, 5668, 6142, 6570, 6936, 7224, 7448, 7598,
                          7686, 7726, 7740, 7684, 7594, 7494, 7354, 7190};
  int     samp [64];
  longint tsv  [64];
  exp_t   expq [$];

  // Reference: scan the stream by the trigger rules, windows are contiguous samples.
  task automatic model(input bit mode, input int th, input int n, input int win);
    int  i;
    bit  pv;
    int  prv;
    bit  hit;
    exp_t e;
    i = 0; pv = 1'b0; prv = 0;
    expq.delete();
    while (i < n) begin
      hit = mode ? (pv && (samp[i] - prv > th)) : (samp[i] > th);
      if (hit) begin
        if (i + win > n) break;
        e.ts = tsv[i]; e.peak = samp[i]; e.idx = 0; e.sum = 0;
        for (int j = 0; j < win; j++) begin
          e.sum += samp[i + j];
          if (samp[i + j] > e.peak) begin
            e.peak = samp[i + j];
            e.idx  = j;
          end
        end
        expq.push_back(e);
        prv = samp[i + win - 1];
        pv  = 1'b1;
        i  += win;
      end else begin
        prv = samp[i];
        pv  = 1'b1;
        i++;
      end
    end
  endtask

  initial begin
    row_t   rows [3];
    bit     ok;
    int     base;
    longint t;
    int     p, ix, s;
    int     c_snap, s_snap;

    ready[0] = 1'b0;
    ready[1] = 1'b0;
    force_empty[0] = 1'b0;
    force_empty[1] = 1'b0;

    // Reset state.
    tick();
    for (int k = 0; k < 2; k++) begin
      get_out(k, t, p, ix, s);
      check($sformatf("reset rd_en%0d", k), longint'(rd_en[k]), 0);
      check($sformatf("reset valid%0d", k), longint'(valid[k]), 0);
      check($sformatf("reset evc%0d", k), longint'(evc[k]), 0);
      check($sformatf("reset ts%0d", k), t, 0);
      check($sformatf("reset peak%0d", k), longint'(p), 0);
      check($sformatf("reset idx%0d", k), longint'(ix), 0);
      check($sformatf("reset sum%0d", k), longint'(s), 0);
    end

    rows[0] = '{mode:1'b0, thr:5000, k:0, exp_ts:1000, exp_peak:7740, exp_idx:10, exp_sum:113220, exp_rd:16};
    rows[1] = '{mode:1'b0, thr:6000, k:1, exp_ts:1002, exp_peak:7726, exp_idx:7,  exp_sum:57330,  exp_rd:10};
    rows[2] = '{mode:1'b1, thr:450,  k:1, exp_ts:1001, exp_peak:7686, exp_idx:7,  exp_sum:55272,  exp_rd:9};

    for (int r = 0; r < 3; r++) begin
      trig_mode = rows[r].mode;
      thr       = 16'(rows[r].thr);
      do_reset();
      base = rd_pulses[rows[r].k];
      for (int i = 0; i < 16; i++) push(rows[r].k, 1000 + i, stream[i]);
      wait_valid(rows[r].k, ok);
      if (ok) begin
        get_out(rows[r].k, t, p, ix, s);
        check($sformatf("row%0d ts", r), t, rows[r].exp_ts);
        check($sformatf("row%0d peak", r), longint'(p), longint'(rows[r].exp_peak));
        check($sformatf("row%0d idx", r), longint'(ix), longint'(rows[r].exp_idx));
        check($sformatf("row%0d sum", r), longint'(s), longint'(rows[r].exp_sum));
        check($sformatf("row%0d reads", r), longint'(rd_pulses[rows[r].k] - base), longint'(rows[r].exp_rd));
        accept(rows[r].k);
        check($sformatf("row%0d evc", r), longint'(evc[rows[r].k]), 1);
      end
    end

    // Backpressure: record held, no reads while ready is low.
    trig_mode = 1'b0;
    thr = 16'd6000;
    do_reset();
    for (int i = 0; i < 16; i++) push(1, 2000 + i, stream[i]);
    wait_valid(1, ok);
    if (ok) begin
      c_snap = int'(cnt[1]);
      s_snap = int'(sum1);
      for (int i = 0; i < 20; i++) begin
        tick();
        check("hold valid", longint'(valid[1]), 1);
        check("hold rd_en", longint'(rd_en[1]), 0);
        check("hold count", longint'(cnt[1]), longint'(c_snap));
        check("hold sum", longint'(sum1), longint'(s_snap));
        check("hold evc", longint'(evc[1]), 0);
      end
      check("hold ts", longint'(ts[1]), 2002);
      accept(1);
      check("post-accept rd_en", longint'(rd_en[1]), 1);
      check("post-accept evc", longint'(evc[1]), 1);
      tick();
      check("evc once", longint'(evc[1]), 1);
    end

    // FIFO empty mid-window: capture waits and the result is unchanged.
    do_reset();
    base = rd_pulses[1];
    for (int i = 0; i < 16; i++) push(1, 1000 + i, stream[i]);
    wait_reads(1, base, 5);
    force_empty[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty rd_en", longint'(rd_en[1]), 0);
      check("empty valid", longint'(valid[1]), 0);
    end
    force_empty[1] = 1'b0;
    wait_valid(1, ok);
    if (ok) begin
      get_out(1, t, p, ix, s);
      check("stall ts", t, 1002);
      check("stall peak", longint'(p), 7726);
      check("stall idx", longint'(ix), 7);
      check("stall sum", longint'(s), 57330);
      check("stall reads", longint'(rd_pulses[1] - base), 10);
      accept(1);
    end

    // Reset mid-capture: partial window dropped, fresh event from new samples.
    do_reset();
    base = rd_pulses[1];
    for (int i = 0; i < 16; i++) push(1, 1000 + i, stream[i]);
    wait_reads(1, base, 6);
    reset_p = 1'b1;
    tick();
    check("midreset valid", longint'(valid[1]), 0);
    check("midreset evc", longint'(evc[1]), 0);
    check("midreset rd_en", longint'(rd_en[1]), 0);
    wr_ptr[1] = rd_ptr[1];
    tick();
    reset_p = 1'b0;
    for (int i = 0; i < 16; i++) push(1, 3000 + i, stream[i]);
    wait_valid(1, ok);
    if (ok) begin
      get_out(1, t, p, ix, s);
      check("fresh ts", t, 3002);
      check("fresh sum", longint'(s), 57330);
      check("fresh idx", longint'(ix), 7);
      accept(1);
      check("fresh evc", longint'(evc[1]), 1);
    end

    // Random streams against the reference model (WIN_LEN 8).
    for (int run = 0; run < 6; run++) begin
      int n = 64;
      int th;
      trig_mode = 1'(run % 2);
      th = trig_mode ? int'($urandom_range(200, 700)) : int'($urandom_range(500, 950));
      thr = 16'(th);
      do_reset();
      base = rd_pulses[1];
      for (int i = 0; i < n; i++) begin
        samp[i] = int'($urandom_range(0, 1000));
        tsv[i]  = {32'($urandom), 32'($urandom)};
        push(1, tsv[i], samp[i]);
      end
      model(trig_mode, th, n, 8);
      for (int e = 0; e < expq.size(); e++) begin
        wait_valid(1, ok);
        if (!ok) break;
        get_out(1, t, p, ix, s);
        check($sformatf("rnd%0d ev%0d ts", run, e), t, expq[e].ts);
        check($sformatf("rnd%0d ev%0d peak", run, e), longint'(p), longint'(expq[e].peak));
        check($sformatf("rnd%0d ev%0d idx", run, e), longint'(ix), longint'(expq[e].idx));
        check($sformatf("rnd%0d ev%0d sum", run, e), longint'(s), longint'(expq[e].sum));
        for (int d = int'($urandom_range(0, 3)); d > 0; d--) tick();
        accept(1);
      end
      for (int i = 0; i < 40; i++) tick();
      check($sformatf("rnd%0d no extra valid", run), longint'(valid[1]), 0);
      check($sformatf("rnd%0d evc", run), longint'(evc[1]), longint'(expq.size()));
      check($sformatf("rnd%0d reads", run), longint'(rd_pulses[1] - base), longint'(n));
    end

    check("overread dut16", longint'(overread[0]), 0);
    check("overread dut8", longint'(overread[1]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
